// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo types: function codes, CDB owner encodings and ROB age helper.
package tomasulo_pkg;

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_MUL = 4'b0010;
  localparam logic [3:0] FN_DIV = 4'b0011;

  typedef enum logic [1:0] {
    CDB_NONE = 2'b00,
    CDB_ADD  = 2'b01,
    CDB_MUL  = 2'b10
  } cdb_src_e;

  // Distance from the ROB head, modulo the ROB size; smaller is older.
  function automatic logic [7:0] rob_age(input logic [7:0] idx, input logic [7:0] head,
                                         input int unsigned w);
    logic [7:0] mask;
    mask = 8'((32'd1 << w) - 32'd1);
    return (idx - head) & mask;
  endfunction

endpackage

// File: rtl/rs_issue_scheduler_age_select.sv
// Combinational oldest-ready picker for one reservation station; ties go to the lower index.
module age_select
  import tomasulo_pkg::*;
#(
  parameter int RS_DEPTH = 3,
  parameter int ROB_W    = 3
) (
  input  logic [RS_DEPTH-1:0]       rdy_i,
  input  logic [RS_DEPTH*ROB_W-1:0] rob_i,
  input  logic [ROB_W-1:0]          rob_head_i,
  output logic                      vld_o,
  output logic [1:0]                idx_o,
  output logic [7:0]                age_o
);

  logic [7:0] age_c;

  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    age_o = '0;
    age_c = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      age_c = rob_age(8'(rob_i[i*ROB_W +: ROB_W]), 8'(rob_head_i), ROB_W);
      // Strict compare keeps the lower index on equal age.
      if (rdy_i[i] && (!vld_o || age_c < age_o)) begin
        vld_o = 1'b1;
        idx_o = 2'(i);
        age_o = age_c;
      end
    end
  end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Issue scheduler for add/sub and mul/div stations with CDB slot reservation.
// Optional counters enabled by defining SCHED_STATS_EN.
module rs_issue_scheduler
  import tomasulo_pkg::*;
#(
  parameter int RS_DEPTH = 3,
  parameter int ROB_W    = 3,
  parameter int ADD_LAT  = 1,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 6
) (
  input  logic                      clk1,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic [ROB_W-1:0]          rob_head,
  input  logic [RS_DEPTH-1:0]       add_rdy,
  input  logic [RS_DEPTH*ROB_W-1:0] add_rob,
  input  logic [RS_DEPTH-1:0]       mul_rdy,
  input  logic [RS_DEPTH*ROB_W-1:0] mul_rob,
  input  logic [RS_DEPTH-1:0]       mul_is_div,
  output logic                      add_gnt,
  output logic [1:0]                add_gnt_idx,
  output logic                      mul_gnt,
  output logic [1:0]                mul_gnt_idx,
  output logic                      mul_busy,
  output logic [1:0]                cdb_src
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]               stat_add_issued,
  output logic [15:0]               stat_mul_issued,
  output logic [15:0]               stat_cdb_stall
`endif
);

  localparam int CNT_W = $clog2(DIV_LAT + 1);

  logic [DIV_LAT:1][1:0] slot_q, slot_d, slot_sh;
  logic [CNT_W-1:0]      mul_cnt_q, mul_cnt_d;

  logic       add_sel_vld, mul_sel_vld;
  logic [1:0] add_sel_idx, mul_sel_idx;
  logic [7:0] add_sel_age, mul_sel_age;
  int         mul_lat;
  logic       add_slot_free, mul_slot_free, mul_unit_free;
  logic       add_cand, mul_cand, same_slot, add_wins;

  age_select #(.RS_DEPTH(RS_DEPTH), .ROB_W(ROB_W)) u_add_sel (
    .rdy_i(add_rdy), .rob_i(add_rob), .rob_head_i(rob_head),
    .vld_o(add_sel_vld), .idx_o(add_sel_idx), .age_o(add_sel_age)
  );

  age_select #(.RS_DEPTH(RS_DEPTH), .ROB_W(ROB_W)) u_mul_sel (
    .rdy_i(mul_rdy), .rob_i(mul_rob), .rob_head_i(rob_head),
    .vld_o(mul_sel_vld), .idx_o(mul_sel_idx), .age_o(mul_sel_age)
  );

  always_comb begin
    slot_sh = '0;
    for (int k = 1; k < DIV_LAT; k++) slot_sh[k] = slot_q[k+1];

    mul_lat       = mul_is_div[mul_sel_idx] ? DIV_LAT : MUL_LAT;
    add_slot_free = (slot_sh[ADD_LAT] == CDB_NONE);
    mul_slot_free = 1'b0;
    for (int k = 1; k <= DIV_LAT; k++)
      if (k == mul_lat) mul_slot_free = (slot_sh[k] == CDB_NONE);

    // The unit frees in the cycle its result owns the CDB, i.e. once the count reaches 0 after this edge.
    mul_unit_free = (mul_cnt_q <= CNT_W'(1));
    add_cand      = add_sel_vld && add_slot_free;
    mul_cand      = mul_sel_vld && mul_unit_free && mul_slot_free;
    same_slot     = add_cand && mul_cand && (ADD_LAT == mul_lat);
    add_wins      = (add_sel_age <= mul_sel_age);

    add_gnt     = reset_n && !flush && add_cand && !(same_slot && !add_wins);
    mul_gnt     = reset_n && !flush && mul_cand && !(same_slot && add_wins);
    add_gnt_idx = add_sel_idx;
    mul_gnt_idx = mul_sel_idx;

    slot_d = slot_sh;
    if (add_gnt) slot_d[ADD_LAT] = CDB_ADD;
    for (int k = 1; k <= DIV_LAT; k++)
      if (mul_gnt && k == mul_lat) slot_d[k] = CDB_MUL;

    mul_cnt_d = mul_cnt_q;
    if (mul_gnt)                mul_cnt_d = CNT_W'(mul_lat);
    else if (mul_cnt_q != '0)   mul_cnt_d = mul_cnt_q - CNT_W'(1);

    if (flush) begin
      slot_d    = '0;
      mul_cnt_d = '0;
    end
  end

  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      slot_q    <= '0;
      mul_cnt_q <= '0;
    end else begin
      slot_q    <= slot_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  // Slot 1 is the reservation being written on the CDB this cycle.
  assign cdb_src  = slot_q[1];
  assign mul_busy = (mul_cnt_q != '0);

`ifdef SCHED_STATS_EN
  logic [15:0] stat_add_q, stat_add_d, stat_mul_q, stat_mul_d, stat_stall_q, stat_stall_d;
  logic        stall_c;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  always_comb begin
    // Outside flush/reset, a ready pick is withheld only by slot occupancy or a same-slot loss.
    stall_c = (add_sel_vld && !add_gnt) || (mul_sel_vld && mul_unit_free && !mul_gnt);
    stat_add_d   = sat_inc(stat_add_q, add_gnt);
    stat_mul_d   = sat_inc(stat_mul_q, mul_gnt);
    stat_stall_d = sat_inc(stat_stall_q, stall_c);
    if (flush) begin
      stat_add_d   = '0;
      stat_mul_d   = '0;
      stat_stall_d = '0;
    end
  end

  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      stat_add_q   <= '0;
      stat_mul_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_add_q   <= stat_add_d;
      stat_mul_q   <= stat_mul_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_add_issued = stat_add_q;
  assign stat_mul_issued = stat_mul_q;
  assign stat_cdb_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler: vector table for picking, sequences for timing corners.
module tb_rs_issue_scheduler;

  logic       clk1 = 1'b0;
  logic       reset_n, flush;
  logic [2:0] rob_head, add_rdy, mul_rdy, mul_is_div;
  logic [8:0] add_rob, mul_rob;
  logic       add_gnt, mul_gnt, mul_busy;
  logic [1:0] add_gnt_idx, mul_gnt_idx, cdb_src;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk1 = ~clk1;

  rs_issue_scheduler dut (
    .clk1(clk1), .reset_n(reset_n), .flush(flush), .rob_head(rob_head),
    .add_rdy(add_rdy), .add_rob(add_rob), .mul_rdy(mul_rdy), .mul_rob(mul_rob),
    .mul_is_div(mul_is_div), .add_gnt(add_gnt), .add_gnt_idx(add_gnt_idx),
    .mul_gnt(mul_gnt), .mul_gnt_idx(mul_gnt_idx), .mul_busy(mul_busy), .cdb_src(cdb_src)
  );

  typedef struct {
    logic [2:0] head;
    logic [2:0] a_rdy;
    logic [8:0] a_rob;
    logic [2:0] m_rdy;
    logic [8:0] m_rob;
    logic [2:0] m_div;
    logic       e_ag;
    logic [1:0] e_ai;
    logic       e_mg;
    logic [1:0] e_mi;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic mid();
    @(negedge clk1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Entry i ROB index lives in bits [3i+:3]; concatenations list entry 2 first.
    vt[0] = '{3'd0, 3'b101, {3'd1, 3'd0, 3'd2}, 3'b000, 9'd0, 3'b000, 1'b1, 2'd2, 1'b0, 2'd0};
    vt[1] = '{3'd6, 3'b011, {3'd0, 3'd7, 3'd0}, 3'b000, 9'd0, 3'b000, 1'b1, 2'd1, 1'b0, 2'd0};
    vt[2] = '{3'd4, 3'b000, {3'd7, 3'd6, 3'd5}, 3'b000, 9'd0, 3'b000, 1'b0, 2'd0, 1'b0, 2'd0};
    vt[3] = '{3'd0, 3'b111, {3'd4, 3'd3, 3'd5}, 3'b111, {3'd2, 3'd7, 3'd6}, 3'b000, 1'b1, 2'd1, 1'b1, 2'd2};
    vt[4] = '{3'd2, 3'b110, {3'd4, 3'd4, 3'd0}, 3'b000, 9'd0, 3'b000, 1'b1, 2'd1, 1'b0, 2'd0};
    vt[5] = '{3'd5, 3'b000, 9'd0, 3'b111, {3'd5, 3'd6, 3'd1}, 3'b100, 1'b0, 2'd0, 1'b1, 2'd2};
    vt[6] = '{3'd3, 3'b100, {3'd2, 3'd0, 3'd0}, 3'b001, {3'd0, 3'd0, 3'd3}, 3'b000, 1'b1, 2'd2, 1'b1, 2'd0};
    vt[7] = '{3'd7, 3'b111, {3'd0, 3'd1, 3'd6}, 3'b011, {3'd0, 3'd2, 3'd7}, 3'b000, 1'b1, 2'd2, 1'b1, 2'd0};

    reset_n = 1'b1; flush = 1'b0; rob_head = '0;
    add_rdy = 3'b111; add_rob = '0; mul_rdy = 3'b111; mul_rob = '0; mul_is_div = '0;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk1);
    mid();
    chk("reset_add_gnt", add_gnt, 0);
    chk("reset_mul_gnt", mul_gnt, 0);
    chk("reset_cdb_src", cdb_src, 0);
    chk("reset_mul_busy", mul_busy, 0);
    #1;
    add_rdy = '0; mul_rdy = '0; reset_n = 1'b1;

    // Table: one vector per cycle, followed by a flush cycle to clear reservations.
    for (int i = 0; i < 8; i++) begin
      tick();
      flush = 1'b0; rob_head = vt[i].head;
      add_rdy = vt[i].a_rdy; add_rob = vt[i].a_rob;
      mul_rdy = vt[i].m_rdy; mul_rob = vt[i].m_rob; mul_is_div = vt[i].m_div;
      mid();
      chk($sformatf("vec%0d_add_gnt", i), add_gnt, vt[i].e_ag);
      if (vt[i].e_ag) chk($sformatf("vec%0d_add_idx", i), add_gnt_idx, vt[i].e_ai);
      chk($sformatf("vec%0d_mul_gnt", i), mul_gnt, vt[i].e_mg);
      if (vt[i].e_mg) chk($sformatf("vec%0d_mul_idx", i), mul_gnt_idx, vt[i].e_mi);
      tick();
      add_rdy = '0; mul_rdy = '0; flush = 1'b1;
    end

    // Add path: grant, CDB ownership one cycle later.
    tick();
    flush = 1'b0; rob_head = 3'd0; add_rdy = 3'b101; add_rob = {3'd1, 3'd0, 3'd2};
    mid();
    chk("addlat_gnt", add_gnt, 1);
    chk("addlat_idx", add_gnt_idx, 2);
    chk("addlat_cdb_t0", cdb_src, 2'b00);
    tick(); add_rdy = '0;
    mid(); chk("addlat_cdb_t1", cdb_src, 2'b01);
    tick();
    mid(); chk("addlat_cdb_t2", cdb_src, 2'b00);

    // CDB conflict: MUL at t blocks an add at t+2.
    tick(); mul_rdy = 3'b001; mul_rob = 9'd0; mul_is_div = '0;
    mid(); chk("conf_mul_gnt", mul_gnt, 1);
    tick(); mul_rdy = '0;
    mid(); chk("conf_busy_t1", mul_busy, 1);
    tick(); add_rdy = 3'b001; add_rob = 9'd1;
    mid();
    chk("conf_add_blocked_t2", add_gnt, 0);
    chk("conf_cdb_t2", cdb_src, 2'b00);
    tick();
    mid();
    chk("conf_add_gnt_t3", add_gnt, 1);
    chk("conf_cdb_t3", cdb_src, 2'b10);
    chk("conf_busy_t3", mul_busy, 1);
    tick(); add_rdy = '0;
    mid();
    chk("conf_cdb_t4", cdb_src, 2'b01);
    chk("conf_busy_t4", mul_busy, 0);

    // DIV occupancy: next mul waits until the DIV result owns the CDB.
    tick(); mul_rdy = 3'b001; mul_is_div = 3'b001; mul_rob = 9'd0;
    mid();
    chk("div_gnt", mul_gnt, 1);
    chk("div_idx", mul_gnt_idx, 0);
    tick(); mul_rdy = 3'b010; mul_is_div = 3'b000; mul_rob = {3'd0, 3'd1, 3'd0};
    for (int c = 1; c <= 5; c++) begin
      mid();
      chk($sformatf("div_busy_t%0d", c), mul_busy, 1);
      chk($sformatf("div_hold_t%0d", c), mul_gnt, 0);
      tick();
    end
    mid();
    chk("div_busy_t6", mul_busy, 1);
    chk("div_next_gnt_t6", mul_gnt, 1);
    chk("div_next_idx_t6", mul_gnt_idx, 1);
    chk("div_cdb_t6", cdb_src, 2'b10);
    tick(); mul_rdy = '0;
    mid();
    chk("div_busy_t7", mul_busy, 1);
    chk("div_cdb_t7", cdb_src, 2'b00);
    tick();
    tick();
    mid(); chk("div_mul_cdb_t9", cdb_src, 2'b10);
    tick();
    mid(); chk("div_idle_t10", mul_busy, 0);

    // Flush mid-DIV: reservation dropped, unit freed.
    tick(); mul_rdy = 3'b001; mul_is_div = 3'b001; mul_rob = 9'd0;
    mid(); chk("fl_div_gnt", mul_gnt, 1);
    tick(); mul_rdy = '0;
    tick();
    flush = 1'b1; add_rdy = 3'b001; add_rob = 9'd0; mul_rdy = 3'b010; mul_is_div = '0;
    mid();
    chk("fl_add_gnt_t2", add_gnt, 0);
    chk("fl_mul_gnt_t2", mul_gnt, 0);
    tick(); flush = 1'b0; add_rdy = '0; mul_rdy = '0;
    mid();
    chk("fl_busy_t3", mul_busy, 0);
    chk("fl_cdb_t3", cdb_src, 2'b00);
    for (int c = 4; c <= 8; c++) begin
      tick();
      mid();
      chk($sformatf("fl_cdb_t%0d", c), cdb_src, 2'b00);
    end

    // Flush mid-DIV again, then a new mul straight after the flush.
    tick(); mul_rdy = 3'b001; mul_is_div = 3'b001; mul_rob = 9'd0;
    mid(); chk("fl2_div_gnt", mul_gnt, 1);
    tick(); mul_rdy = '0;
    tick(); flush = 1'b1;
    tick(); flush = 1'b0; mul_rdy = 3'b010; mul_is_div = '0; mul_rob = {3'd0, 3'd1, 3'd0};
    mid();
    chk("fl2_mul_gnt_t3", mul_gnt, 1);
    chk("fl2_mul_idx_t3", mul_gnt_idx, 1);
    tick(); mul_rdy = '0;
    repeat (4) tick();

    // Async reset with reservations pending.
    tick();
    rob_head = 3'd0; add_rdy = 3'b001; add_rob = 9'd0;
    mul_rdy = 3'b001; mul_rob = 9'd1; mul_is_div = '0;
    mid();
    chk("rst_add_gnt_t0", add_gnt, 1);
    chk("rst_mul_gnt_t0", mul_gnt, 1);
    tick(); add_rdy = '0; mul_rdy = '0;
    mid();
    chk("rst_cdb_t1", cdb_src, 2'b01);
    chk("rst_busy_t1", mul_busy, 1);
    add_rdy = 3'b001; mul_rdy = 3'b001;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_cdb_now", cdb_src, 2'b00);
    chk("rst_busy_now", mul_busy, 0);
    chk("rst_add_gnt_now", add_gnt, 0);
    chk("rst_mul_gnt_now", mul_gnt, 0);
    add_rdy = '0; mul_rdy = '0;
    tick();
    mid();
    #1 reset_n = 1'b1;
    tick();
    mid();
    chk("rst_cdb_t3", cdb_src, 2'b00);
    chk("rst_busy_t3", mul_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
